// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the MEM-stage load/store unit: funct3 codes,
// LSU state encoding and the alignment rule.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, BUS, DONE} lsu_state_t;

  // funct3[1:0] encodes the access size for both loads and stores
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (funct3[1:0])
      2'b01:   bad = addr_lo[0];
      2'b10:   bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load aligner: picks the addressed byte/half lane out of the
// bus word and sign- or zero-extends it according to funct3.
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_word
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = rdata >> {addr_lo, 3'b000};
    load_word = rdata;
    case (funct3)
      F3_LB:   load_word = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_word = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  load_word = {24'h000000, shifted[7:0]};
      F3_LHU:  load_word = {16'h0000, shifted[15:0]};
      default: load_word = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: runs one Wishbone B4 classic cycle per EX/MEM
// memory request. Optional ack timeout is enabled with `define LSU_TIMEOUT_EN.
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  stall_req,
  output logic                  misalign,
  output logic                  bus_err,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic [3:0]            wb_sel_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i
);

  lsu_state_t state, state_next;

  logic                  req, bad_align, issue, timeout, bus_done, kill, ack_ok;
  logic                  flushed_q, req_read;
  logic [1:0]            req_lo;
  logic [2:0]            req_f3;
  logic [3:0]            sel_calc;
  logic [DATA_WIDTH-1:0] dat_calc, aligned_word;

  assign req       = (mem_read | mem_write) & ~flush;
  assign bad_align = is_misaligned(funct3, addr[1:0]);
  assign issue     = (state == IDLE) && req && !bad_align;
  assign bus_done  = wb_ack_i | wb_err_i | timeout;
  assign kill      = flushed_q | flush;
  assign ack_ok    = wb_ack_i & ~wb_err_i & ~timeout;
  assign stall_req = issue || (state == BUS);

  always_comb begin
    sel_calc = 4'hF;
    dat_calc = store_data;
    case (funct3[1:0])
      2'b00: begin
        sel_calc = 4'b0001 << addr[1:0];
        dat_calc = {4{store_data[7:0]}};
      end
      2'b01: begin
        sel_calc = 4'b0011 << addr[1:0];
        dat_calc = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  lsu_load_align u_align (
    .rdata     (wb_dat_i),
    .addr_lo   (req_lo),
    .funct3    (req_f3),
    .load_word (aligned_word)
  );

`ifdef LSU_TIMEOUT_EN
  logic [7:0] tmo_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               tmo_count <= 8'd0;
    else if (issue)          tmo_count <= 8'd0;
    else if (state == BUS)   tmo_count <= tmo_count + 8'd1;
  end

  // fires on the TIMEOUT_CYCLES-th BUS cycle; a real ack in that cycle wins
  assign timeout = (state == BUS) && !wb_ack_i && !wb_err_i &&
                   (tmo_count == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (issue) state_next = BUS;
      BUS:     if (bus_done) state_next = kill ? IDLE : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A flushed cycle still runs to completion on the bus, but its result and
  // any error are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= 4'h0;
      load_data <= '0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      flushed_q <= 1'b0;
      req_read  <= 1'b0;
      req_lo    <= 2'b00;
      req_f3    <= 3'b000;
    end else begin
      misalign <= (state == IDLE) && req && bad_align;
      bus_err  <= 1'b0;
      case (state)
        IDLE: if (issue) begin
          wb_cyc_o  <= 1'b1;
          wb_stb_o  <= 1'b1;
          wb_we_o   <= mem_write;
          wb_adr_o  <= {addr[ADDR_WIDTH-1:2], 2'b00};
          wb_sel_o  <= sel_calc;
          wb_dat_o  <= mem_write ? dat_calc : '0;
          req_read  <= ~mem_write;
          req_lo    <= addr[1:0];
          req_f3    <= funct3;
          flushed_q <= 1'b0;
        end
        BUS: if (bus_done) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          wb_we_o  <= 1'b0;
          if (!kill) begin
            load_data <= (ack_ok && req_read) ? aligned_word : '0;
            bus_err   <= ~ack_ok;
          end
        end else begin
          flushed_q <= kill;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized self-checking bench for mem_stage_lsu against a lane/size-based
// reference model and a simple Wishbone slave driven from the bench.
module tb_mem_stage_lsu;

  localparam int TMO = 8;

  logic        clk, reset, flush, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, load_data, wb_adr_o, wb_dat_o, wb_dat_i;
  logic        stall_req, misalign, bus_err, wb_cyc_o, wb_stb_o, wb_we_o;
  logic        wb_ack_i, wb_err_i;
  logic [3:0]  wb_sel_o;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_load;

  mem_stage_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .flush(flush), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .addr(addr),
    .store_data(store_data), .load_data(load_data), .stall_req(stall_req),
    .misalign(misalign), .bus_err(bus_err), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] refLoad(input logic [31:0] word, input int lane,
                                          input logic [2:0] f3);
    int b, h;
    b = int'((word >> (8 * lane)) & 32'hFF);
    h = int'((word >> (8 * lane)) & 32'hFFFF);
    case (f3)
      3'd0:    return (b >= 128) ? 32'(b - 256) : 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] refSel(input logic [2:0] f3, input int lane);
    case (f3[1:0])
      2'd0:    return 32'(1 << lane);
      2'd1:    return 32'(3 << lane);
      default: return 32'hF;
    endcase
  endfunction

  function automatic logic [31:0] refDat(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'd0:    return (d % 256) * 32'h01010101;
      2'd1:    return (d % 65536) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  // One aligned request: issue, lat BUS cycles (slave answers in cycle lat),
  // then DONE (or straight back to IDLE if a flush landed during the cycle).
  task automatic applyStimulus(input bit is_write, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] sdata,
                               input logic [31:0] rdata, input int lat,
                               input bit give_ack, input bit give_err,
                               input int flush_at);
    int stalls;
    bit killed, expect_err;
    int lane;
    lane   = int'(a % 4);
    killed = 1'b0;
    @(negedge clk);
    mem_read = !is_write; mem_write = is_write; funct3 = f3; addr = a;
    store_data = sdata; flush = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    #1;
    checkOutput("issue_stall", 32'(stall_req), 32'd1);
    stalls = int'(stall_req);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      flush  = (k == flush_at);
      killed = killed | flush;
      wb_dat_i = $urandom;
      wb_ack_i = 1'b0; wb_err_i = 1'b0;
      if (k == lat) begin
        wb_ack_i = give_ack; wb_err_i = give_err; wb_dat_i = rdata;
      end
      #1;
      checkOutput("cyc_held", 32'(wb_cyc_o), 32'd1);
      checkOutput("stb_held", 32'(wb_stb_o), 32'd1);
      checkOutput("we", 32'(wb_we_o), 32'(is_write));
      checkOutput("adr", wb_adr_o, a - (a % 4));
      checkOutput("sel", 32'(wb_sel_o), refSel(f3, lane));
      if (is_write) checkOutput("dat_o", wb_dat_o, refDat(f3, sdata));
      stalls += int'(stall_req);
    end
    @(negedge clk);
    wb_ack_i = 1'b0; wb_err_i = 1'b0; flush = 1'b0;
    if (killed) begin mem_read = 1'b0; mem_write = 1'b0; end
    #1;
    checkOutput("cyc_drop", 32'(wb_cyc_o), 32'd0);
    checkOutput("stb_drop", 32'(wb_stb_o), 32'd0);
    checkOutput("done_stall", 32'(stall_req), 32'd0);
    checkOutput("stall_count", 32'(stalls), 32'(lat + 1));
    if (!killed) begin
      expect_err = give_err || !give_ack;
      exp_load = (expect_err || is_write) ? 32'd0 : refLoad(rdata, lane, f3);
      checkOutput("bus_err", 32'(bus_err), 32'(expect_err));
    end else begin
      checkOutput("flush_no_err", 32'(bus_err), 32'd0);
    end
    checkOutput("load_data", load_data, exp_load);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    checkOutput("no_reissue", 32'(wb_cyc_o), 32'd0);
    checkOutput("err_once", 32'(bus_err), 32'd0);
  endtask

  task automatic misalignCase(input bit is_write, input logic [2:0] f3,
                              input logic [31:0] a);
    @(negedge clk);
    mem_read = !is_write; mem_write = is_write; funct3 = f3; addr = a;
    #1;
    checkOutput("mis_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    checkOutput("mis_pulse", 32'(misalign), 32'd1);
    checkOutput("mis_no_cyc", 32'(wb_cyc_o), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("mis_once", 32'(misalign), 32'd0);
    checkOutput("mis_load", load_data, exp_load);
  endtask

  initial begin
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] a;
    int          lat, r, fat, pick, size;
    reset = 1'b1; flush = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'd0; addr = 32'd0; store_data = 32'd0; wb_dat_i = 32'd0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; exp_load = 32'd0;
    #13;
    checkOutput("rst_cyc", 32'(wb_cyc_o), 32'd0);
    checkOutput("rst_stb", 32'(wb_stb_o), 32'd0);
    checkOutput("rst_sel", 32'(wb_sel_o), 32'd0);
    checkOutput("rst_load", load_data, 32'd0);
    checkOutput("rst_stall", 32'(stall_req), 32'd0);
    checkOutput("rst_err", 32'(bus_err | misalign), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(1'b0, 3'd2, 32'h1000, 32'd0, 32'hDEADBEEF, 3, 1'b1, 1'b0, 0);
    checkOutput("lw_const", load_data, 32'hDEADBEEF);
    applyStimulus(1'b0, 3'd0, 32'h1003, 32'd0, 32'h80112233, 1, 1'b1, 1'b0, 0);
    checkOutput("lb_const", load_data, 32'hFFFFFF80);
    applyStimulus(1'b0, 3'd4, 32'h1003, 32'd0, 32'h80112233, 2, 1'b1, 1'b0, 0);
    checkOutput("lbu_const", load_data, 32'h00000080);
    applyStimulus(1'b1, 3'd1, 32'h2002, 32'h0000ABCD, 32'd0, 1, 1'b1, 1'b0, 0);
    misalignCase(1'b0, 3'd2, 32'h1001);
    applyStimulus(1'b0, 3'd2, 32'h3000, 32'd0, 32'h12345678, 3, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 3'd5, 32'h3002, 32'd0, 32'hF00D0000, 2, 1'b0, 1'b1, 0);
    applyStimulus(1'b0, 3'd1, 32'h3002, 32'd0, 32'h8001AAAA, 1, 1'b1, 1'b0, 0);
    applyStimulus(1'b0, 3'd2, 32'h3004, 32'd0, 32'h55555555, 1, 1'b1, 1'b1, 0);

    // reset in the middle of a bus cycle
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'd2; addr = 32'h4000;
    @(negedge clk);
    mem_read = 1'b0;
    #1;
    checkOutput("pre_rst_cyc", 32'(wb_cyc_o), 32'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("async_rst_cyc", 32'(wb_cyc_o), 32'd0);
    checkOutput("async_rst_stb", 32'(wb_stb_o), 32'd0);
    checkOutput("async_rst_stall", 32'(stall_req), 32'd0);
    exp_load = 32'd0;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      pick = int'($urandom_range(0, wr ? 2 : 4));
      f3 = 3'((pick < 3) ? pick : pick + 1);
      a = $urandom;
      size = 1 << int'(f3 % 4);
      if ((a % size) != 0) begin
        misalignCase(wr, f3, a);
      end else begin
        lat = int'($urandom_range(1, 4));
        r = int'($urandom_range(0, 7));
        fat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, lat)) : 0;
        applyStimulus(wr, f3, a, $urandom, $urandom, lat, r != 0, r < 2, fat);
      end
    end

`ifdef LSU_TIMEOUT_EN
    applyStimulus(1'b0, 3'd2, 32'h5000, 32'd0, 32'hCAFEF00D, TMO, 1'b0, 1'b0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
